// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one read per cycle to a 1-cycle-latency
// instruction memory and hands {pc, instr} to decode through a 2-entry valid/ready buffer.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  logic [31:0] r_pc;
  logic [31:0] r_pc_q;
  logic        r_inflight;
  logic [1:0]  r_occ;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [31:0] r_buf_instr [2];
  logic [31:0] r_buf_pc    [2];

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_credit;
  logic        w_unused_redirect_lsb;

  assign w_unused_redirect_lsb = ^redirect_pc[1:0];

  assign if_valid = (r_occ != 2'd0);
  assign if_instr = if_valid ? r_buf_instr[r_rd_ptr] : NOP_INSTR;
  assign if_pc    = if_valid ? r_buf_pc[r_rd_ptr]    : 32'd0;

  assign w_pop    = if_valid & if_ready;
  // Entries that will be held once this cycle's pop and the pending response settle.
  assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue  = rst & fetch_en & ~redirect_valid & (w_credit < 3'(BUF_DEPTH));
  assign w_push   = r_inflight & ~redirect_valid;

  assign imem_read = w_issue;
  assign imem_addr = r_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_pc_q     <= 32'd0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
    end else begin
      if (w_issue) begin
        r_pc_q <= r_pc;
        r_pc   <= r_pc + 32'd4;
      end
      r_inflight <= w_issue;
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_buf_instr[r_wr_ptr] <= imem_data;
      r_buf_pc[r_wr_ptr]    <= r_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a default-PC instance plus a second instance whose
// reset PC sits just below the 32-bit wrap point.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;

  logic        imem_read,  imem_read2;
  logic [31:0] imem_addr,  imem_addr2;
  logic [31:0] imem_data,  imem_data2;
  logic        if_valid,   if_valid2;
  logic [31:0] if_instr,   if_instr2;
  logic [31:0] if_pc,      if_pc2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_read(imem_read), .imem_addr(imem_addr),
    .imem_data(imem_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_read(imem_read2), .imem_addr(imem_addr2),
    .imem_data(imem_data2), .if_valid(if_valid2), .if_ready(if_ready),
    .if_instr(if_instr2), .if_pc(if_pc2)
  );

  // Word at address a is ((a/4)+1) * 0x11111111, so 0 -> 0x11111111, 4 -> 0x22222222, ...
  function automatic logic [31:0] word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h1111_1111;
  endfunction

  // Instruction memory models; garbage when no read so stale pushes show up.
  always @(posedge clk) begin
    imem_data  <= imem_read  ? word(imem_addr)  : 32'hDEAD_BEEF;
    imem_data2 <= imem_read2 ? word(imem_addr2) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; if_ready = 1'b0;
    tick(); tick();
    chk("rst_read",  {31'd0, imem_read}, 32'd0);
    chk("rst_addr",  imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0000_0013);
    chk("rst_pc",    if_pc, 32'd0);
    chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);

    // Streaming fill and steady state
    rst = 1'b1; fetch_en = 1'b1; if_ready = 1'b1; #1;
    chk("a0_read",  {31'd0, imem_read}, 32'd1);
    chk("a0_addr",  imem_addr, 32'd0);
    chk("a0_valid", {31'd0, if_valid}, 32'd0);
    chk("wrap_a0",  imem_addr2, 32'hFFFF_FFF8);
    tick();
    chk("a1_addr",  imem_addr, 32'd4);
    chk("a1_valid", {31'd0, if_valid}, 32'd0);
    chk("wrap_a1",  imem_addr2, 32'hFFFF_FFFC);
    tick();
    chk("wrap_a2",    imem_addr2, 32'h0000_0000);
    chk("wrap_a2_rd", {31'd0, imem_read2}, 32'd1);
    chk("wrap_pc",    if_pc2, 32'hFFFF_FFF8);
    for (int k = 0; k < 4; k++) begin
      chk("fill_valid", {31'd0, if_valid}, 32'd1);
      chk("fill_pc",    if_pc, 32'(4 * k));
      chk("fill_instr", if_instr, word(32'(4 * k)));
      chk("fill_addr",  imem_addr, 32'(8 + 4 * k));
      tick();
    end

    // Back-pressure: head 16 held, issuing stops
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_read",  {31'd0, imem_read}, 32'd0);
      chk("bp_valid", {31'd0, if_valid}, 32'd1);
      chk("bp_pc",    if_pc, 32'd16);
      chk("bp_instr", if_instr, word(32'd16));
      tick();
    end
    if_ready = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      chk("rel_pc",   if_pc, 32'(16 + 4 * k));
      chk("rel_addr", imem_addr, 32'(24 + 4 * k));
      tick();
    end

    // Redirect with a pop and an in-flight read
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("rd_pre_pc", if_pc, 32'd28);
    chk("rd_read",   {31'd0, imem_read}, 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("rd_valid", {31'd0, if_valid}, 32'd0);
    chk("rd_instr", if_instr, 32'h0000_0013);
    chk("rd_read1", {31'd0, imem_read}, 32'd1);
    chk("rd_addr",  imem_addr, 32'h0000_0100);
    tick();
    chk("rd_valid1", {31'd0, if_valid}, 32'd0);
    chk("rd_addr1",  imem_addr, 32'h0000_0104);
    tick();
    chk("rd_valid2", {31'd0, if_valid}, 32'd1);
    chk("rd_pc2",    if_pc, 32'h0000_0100);
    chk("rd_instr2", if_instr, word(32'h0000_0100));
    tick();
    chk("rd_pc3",    if_pc, 32'h0000_0104);

    // Halt right after an issue of 0x10C
    tick();
    fetch_en = 1'b0; #1;
    chk("halt_read", {31'd0, imem_read}, 32'd0);
    chk("halt_pc",   if_pc, 32'h0000_0108);
    tick();
    chk("halt_read1",  {31'd0, imem_read}, 32'd0);
    chk("halt_pc1",    if_pc, 32'h0000_010C);
    chk("halt_instr1", if_instr, word(32'h0000_010C));
    tick();
    chk("halt_valid2", {31'd0, if_valid}, 32'd0);
    chk("halt_instr2", if_instr, 32'h0000_0013);
    chk("halt_pc2",    if_pc, 32'd0);
    chk("halt_read2",  {31'd0, imem_read}, 32'd0);

    // Reset mid-stream with a buffered word and a read in flight
    fetch_en = 1'b1; if_ready = 1'b0; #1;
    chk("rs_addr0", imem_addr, 32'h0000_0110);
    tick(); tick();
    chk("rs_pre_pc", if_pc, 32'h0000_0110);
    rst = 1'b0; #1;
    chk("rs_read_in", {31'd0, imem_read}, 32'd0);
    tick();
    chk("rs_valid", {31'd0, if_valid}, 32'd0);
    chk("rs_addr",  imem_addr, 32'd0);
    chk("rs_read",  {31'd0, imem_read}, 32'd0);
    chk("rs_instr", if_instr, 32'h0000_0013);
    rst = 1'b1; #1;
    chk("rs_read1", {31'd0, imem_read}, 32'd1);
    chk("rs_addr1", imem_addr, 32'd0);
    tick();
    chk("rs_valid2", {31'd0, if_valid}, 32'd0);
    chk("rs_addr2",  imem_addr, 32'd4);
    tick();
    chk("rs_valid3", {31'd0, if_valid}, 32'd1);
    chk("rs_pc3",    if_pc, 32'd0);
    chk("rs_instr3", if_instr, 32'h1111_1111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
